// File: rtl/multdiv_pkg.sv
// Shared encodings and helpers for the iterative multiply/divide unit.
package multdiv_pkg;

    // Operation select carried on the op input.
    localparam logic OP_MUL = 1'b0;
    localparam logic OP_DIV = 1'b1;

    // Widest operand the abs helper handles; WIDTH must stay below this.
    localparam int MAX_W = 128;

    // Control states of the unit.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Magnitude of a sign-extended two's complement value. The most negative
    // WIDTH-bit value comes out as the correct unsigned magnitude because the
    // input is sign-extended to MAX_W before negation.
    function automatic logic [MAX_W-1:0] abs_w(input logic [MAX_W-1:0] value);
        return value[MAX_W-1] ? ((~value) + MAX_W'(1)) : value;
    endfunction

endpackage

// File: rtl/multdiv_iter_core.sv
// Shared shift-add / restoring-divide datapath, one radix-2 step per enabled cycle.
module multdiv_iter_core
    import multdiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               load_i,
    input  logic               step_i,
    input  logic               op_i,
    input  logic [WIDTH-1:0]   magA_i,
    input  logic [WIDTH-1:0]   magB_i,
    output logic [2*WIDTH-1:0] prod_o,
    output logic [WIDTH-1:0]   quot_o
);

    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic [WIDTH-1:0] opnd_q;
    logic [WIDTH-1:0] hi_d;
    logic [WIDTH-1:0] lo_d;
    logic [WIDTH-1:0] addend;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH:0]   diff;

    // Compute one step: MUL adds the multiplicand when the low multiplier bit is set and
    // shifts the accumulator right; DIV shifts the remainder left and keeps the subtraction
    // only when it does not borrow, shifting the quotient bit into the low half.
    always_comb begin
        addend  = lo_q[0] ? opnd_q : '0;
        sum     = {1'b0, hi_q} + {1'b0, addend};
        shifted = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
        diff    = {1'b0, shifted} - {1'b0, opnd_q};
        hi_d    = sum[WIDTH:1];
        lo_d    = {sum[0], lo_q[WIDTH-1:1]};
        if (op_i == OP_DIV) begin
            if (diff[WIDTH]) begin
                hi_d = shifted;
                lo_d = {lo_q[WIDTH-2:0], 1'b0};
            end else begin
                hi_d = diff[WIDTH-1:0];
                lo_d = {lo_q[WIDTH-2:0], 1'b1};
            end
        end
    end

    // The post-step values are exported so the controller can fix up the final result
    // on the same edge that performs the last step.
    assign prod_o = {hi_d, lo_d};
    assign quot_o = lo_d;

    // Load magnitudes at the start of an op, otherwise advance one step when enabled.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hi_q   <= '0;
            lo_q   <= '0;
            opnd_q <= '0;
        end else if (load_i) begin
            hi_q   <= '0;
            lo_q   <= (op_i == OP_DIV) ? magA_i : magB_i;
            opnd_q <= (op_i == OP_DIV) ? magB_i : magA_i;
        end else if (step_i) begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

endmodule

// File: rtl/multdiv_iter_unit.sv
// Iterative signed multiply/divide unit with valid/ready handshakes, tag, flush and back-pressure.
module multdiv_iter_unit
    import multdiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [TAG_W-1:0] out_tag,
    output logic             exception,
    output logic             busy
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               start_q;
    logic               op_q;
    logic               sign_q;
    logic               divZero_q;
    logic [WIDTH-1:0]   magA_q;
    logic [WIDTH-1:0]   magB_q;
    logic               outValid_q;
    logic [WIDTH-1:0]   result_q;
    logic [TAG_W-1:0]   outTag_q;
    logic               exc_q;
    logic               busy_q;

    logic               accept;
    logic [MAX_W-1:0]   aExt;
    logic [MAX_W-1:0]   bExt;
    logic [WIDTH-1:0]   magA_d;
    logic [WIDTH-1:0]   magB_d;
    logic               coreLoad;
    logic               coreStep;
    logic [2*WIDTH-1:0] prodMag;
    logic [2*WIDTH-1:0] prodSigned;
    logic [WIDTH:0]     prodTop;
    logic [WIDTH-1:0]   quotMag;
    logic [WIDTH-1:0]   quotSigned;
    logic [WIDTH-1:0]   result_d;
    logic               exc_d;

    assign in_ready = ~flush & ((state_q == ST_IDLE) | ((state_q == ST_DONE) & out_ready));
    assign accept   = in_valid & in_ready;

    assign aExt   = {{(MAX_W-WIDTH){operand_a[WIDTH-1]}}, operand_a};
    assign bExt   = {{(MAX_W-WIDTH){operand_b[WIDTH-1]}}, operand_b};
    assign magA_d = WIDTH'(abs_w(aExt));
    assign magB_d = WIDTH'(abs_w(bExt));

    // The first RUN cycle loads the core from the latched magnitudes; the WIDTH
    // steps follow, which gives the WIDTH+1 cycle accept-to-result latency.
    assign coreLoad = (state_q == ST_RUN) & start_q & ~flush;
    assign coreStep = (state_q == ST_RUN) & ~start_q & ~flush;

    multdiv_iter_core #(.WIDTH(WIDTH)) u_core (
        .clock  (clock),
        .reset  (reset),
        .load_i (coreLoad),
        .step_i (coreStep),
        .op_i   (op_q),
        .magA_i (magA_q),
        .magB_i (magB_q),
        .prod_o (prodMag),
        .quot_o (quotMag)
    );

    assign prodSigned = sign_q ? (-prodMag) : prodMag;
    assign prodTop    = prodSigned[2*WIDTH-1:WIDTH-1];
    assign quotSigned = sign_q ? (-quotMag) : quotMag;

    // Sign fix-up and exception detection; the only positive quotient with its top bit set is MIN/-1.
    always_comb begin
        result_d = prodSigned[WIDTH-1:0];
        exc_d    = ~((&prodTop) | ~(|prodTop));
        if (op_q == OP_DIV) begin
            result_d = quotSigned;
            exc_d    = ~sign_q & quotMag[WIDTH-1];
        end
    end

    // Control FSM with registered outputs; flush overrides everything but reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            start_q    <= 1'b0;
            op_q       <= OP_MUL;
            sign_q     <= 1'b0;
            divZero_q  <= 1'b0;
            magA_q     <= '0;
            magB_q     <= '0;
            outValid_q <= 1'b0;
            result_q   <= '0;
            outTag_q   <= '0;
            exc_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else if (flush) begin
            state_q    <= ST_IDLE;
            start_q    <= 1'b0;
            outValid_q <= 1'b0;
            busy_q     <= 1'b0;
        end else if (accept) begin
            state_q    <= ST_RUN;
            cnt_q      <= '0;
            start_q    <= 1'b1;
            op_q       <= op;
            sign_q     <= operand_a[WIDTH-1] ^ operand_b[WIDTH-1];
            divZero_q  <= (op == OP_DIV) & (operand_b == '0);
            magA_q     <= magA_d;
            magB_q     <= magB_d;
            outTag_q   <= in_tag;
            outValid_q <= 1'b0;
            busy_q     <= 1'b1;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (start_q) begin
                        start_q <= 1'b0;
                        if (divZero_q) begin
                            state_q    <= ST_DONE;
                            outValid_q <= 1'b1;
                            result_q   <= '0;
                            exc_q      <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_LAST) begin
                            state_q    <= ST_DONE;
                            outValid_q <= 1'b1;
                            result_q   <= result_d;
                            exc_q      <= exc_d;
                        end
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_q    <= ST_IDLE;
                        outValid_q <= 1'b0;
                        busy_q     <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_valid = outValid_q;
    assign result    = result_q;
    assign out_tag   = outTag_q;
    assign exception = exc_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_multdiv_iter_unit.sv
// Directed bench for multdiv_iter_unit with a scoreboard of expected results.
module tb_multdiv_iter_unit;
    import multdiv_pkg::*;

    localparam int WIDTH      = 32;
    localparam int TAG_W      = 5;
    localparam int RUN_LAT    = WIDTH + 1;
    localparam int WAIT_LIMIT = 200;

    logic             clock;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic             op;
    logic [WIDTH-1:0] operand_a;
    logic [WIDTH-1:0] operand_b;
    logic [TAG_W-1:0] in_tag;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic [TAG_W-1:0] out_tag;
    logic             exception;
    logic             busy;

    typedef struct packed {
        logic [WIDTH-1:0] result;
        logic [TAG_W-1:0] tag;
        logic             exc;
    } expect_t;

    expect_t    scoreboard[$];
    expect_t    lastExp;
    int         checks;
    int         errors;
    int         cycle;
    int         acceptCycle;
    int         waited;
    int         seenValid;
    logic       rOp;
    logic [31:0] rA;
    logic [31:0] rB;

    multdiv_iter_unit #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .in_tag    (in_tag),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .out_tag   (out_tag),
        .exception (exception),
        .busy      (busy)
    );

    // Free-running clock.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Edge counter used to measure accept-to-result latency.
    initial cycle = 0;
    always @(posedge clock) cycle <= cycle + 1;

    // Reference model using 64-bit signed arithmetic.
    function automatic expect_t model(input logic opIn, input logic [31:0] a, input logic [31:0] b,
                                      input logic [TAG_W-1:0] tag);
        expect_t e;
        longint  sa;
        longint  sb;
        longint  p;
        longint  q;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        e.tag = tag;
        e.result = '0;
        e.exc = 1'b0;
        if (opIn == OP_MUL) begin
            p = sa * sb;
            e.result = p[31:0];
            e.exc = (p != longint'($signed(p[31:0])));
        end else if (b == 32'd0) begin
            e.result = '0;
            e.exc = 1'b1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            e.result = 32'h8000_0000;
            e.exc = 1'b1;
        end else begin
            q = sa / sb;
            e.result = q[31:0];
        end
        return e;
    endfunction

    function automatic int latencyOf(input logic opIn, input logic [31:0] b);
        return (opIn == OP_DIV && b == 32'd0) ? 1 : RUN_LAT;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic checkVal(input string name, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", name, observed, expected);
        end
    endtask

    // Present an op, wait for it to be accepted, optionally record its expected result.
    task automatic applyStimulus(input logic opIn, input logic [31:0] a, input logic [31:0] b,
                                 input logic [TAG_W-1:0] tag, input bit track, output int waitCycles);
        op = opIn;
        operand_a = a;
        operand_b = b;
        in_tag = tag;
        in_valid = 1'b1;
        #1;
        waitCycles = 0;
        while (!in_ready && waitCycles < WAIT_LIMIT) begin
            tick();
            waitCycles++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept_timeout: in_ready=%0b after %0d cycles, required 1", in_ready, waitCycles);
            in_valid = 1'b0;
            return;
        end
        tick();
        acceptCycle = cycle;
        in_valid = 1'b0;
        operand_a = $urandom;
        operand_b = $urandom;
        op = ~opIn;
        in_tag = ~tag;
        if (track) scoreboard.push_back(model(opIn, a, b, tag));
    endtask

    // Wait for the next result and compare it against the head of the scoreboard.
    task automatic checkOutput(input int expLat);
        int n;
        n = 0;
        while (!out_valid && n < WAIT_LIMIT) begin
            tick();
            n++;
        end
        if (!out_valid) begin
            checks++;
            errors++;
            $display("[TB] FAIL result_timeout: out_valid=0 after %0d cycles, required 1", n);
            return;
        end
        if (scoreboard.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL scoreboard_empty: unexpected result %0h, required none", result);
            return;
        end
        lastExp = scoreboard.pop_front();
        checkVal("latency", 64'(cycle - acceptCycle), 64'(expLat));
        checkVal("result", 64'(result), 64'(lastExp.result));
        checkVal("out_tag", 64'(out_tag), 64'(lastExp.tag));
        checkVal("exception", 64'(exception), 64'(lastExp.exc));
    endtask

    // Take the pending result and confirm the unit drops out_valid.
    task automatic consume();
        out_ready = 1'b1;
        tick();
        checkVal("drop_valid", 64'(out_valid), 64'd0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b0;
        in_valid = 1'b0;
        op = OP_MUL;
        operand_a = '0;
        operand_b = '0;
        in_tag = '0;
        flush = 1'b0;
        out_ready = 1'b1;
        #1;

        // Reset values
        checkVal("rst_in_ready", 64'(in_ready), 64'd1);
        checkVal("rst_out_valid", 64'(out_valid), 64'd0);
        checkVal("rst_result", 64'(result), 64'd0);
        checkVal("rst_out_tag", 64'(out_tag), 64'd0);
        checkVal("rst_exception", 64'(exception), 64'd0);
        checkVal("rst_busy", 64'(busy), 64'd0);
        tick();
        tick();
        reset = 1'b1;
        tick();

        // Basic multiply cases
        applyStimulus(OP_MUL, 32'd6, 32'd7, 5'd9, 1'b1, waited);
        checkVal("busy_run", 64'(busy), 64'd1);
        checkOutput(RUN_LAT);
        consume();
        applyStimulus(OP_MUL, 32'hFFFF_FFF9, 32'd3, 5'd1, 1'b1, waited);
        checkOutput(RUN_LAT);
        consume();
        applyStimulus(OP_MUL, 32'h4000_0000, 32'd4, 5'd2, 1'b1, waited);
        checkOutput(RUN_LAT);
        consume();

        // Divide cases including overflow and divide by zero
        applyStimulus(OP_DIV, 32'd100, 32'hFFFF_FFF9, 5'd3, 1'b1, waited);
        checkOutput(RUN_LAT);
        consume();
        applyStimulus(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd4, 1'b1, waited);
        checkOutput(RUN_LAT);
        consume();
        applyStimulus(OP_DIV, 32'd5, 32'd0, 5'd5, 1'b1, waited);
        checkOutput(1);
        consume();

        // Back-pressure: hold the result for 10 cycles, then accept a new op on the release edge
        out_ready = 1'b0;
        applyStimulus(OP_MUL, 32'd123, 32'hFFFF_FFD3, 5'd6, 1'b1, waited);
        checkOutput(RUN_LAT);
        for (int i = 0; i < 10; i++) begin
            tick();
            checkVal("hold_valid", 64'(out_valid), 64'd1);
            checkVal("hold_result", 64'(result), 64'(lastExp.result));
            checkVal("hold_tag", 64'(out_tag), 64'(lastExp.tag));
            checkVal("hold_in_ready", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        applyStimulus(OP_DIV, 32'hFFFF_FC18, 32'd33, 5'd7, 1'b1, waited);
        checkVal("b2b_same_edge", 64'(waited), 64'd0);
        checkVal("b2b_valid_drop", 64'(out_valid), 64'd0);
        checkOutput(RUN_LAT);
        consume();

        // Flush in the middle of RUN kills the op
        applyStimulus(OP_MUL, 32'd1000, 32'd1000, 5'd8, 1'b0, waited);
        repeat (12) tick();
        flush = 1'b1;
        #1;
        checkVal("flush_in_ready", 64'(in_ready), 64'd0);
        tick();
        flush = 1'b0;
        checkVal("flush_busy", 64'(busy), 64'd0);
        seenValid = 0;
        repeat (40) begin
            tick();
            if (out_valid) seenValid++;
        end
        checkVal("flush_no_result", 64'(seenValid), 64'd0);
        applyStimulus(OP_MUL, 32'hFFFF_CFC7, 32'd6789, 5'd10, 1'b1, waited);
        checkOutput(RUN_LAT);
        consume();

        // Asynchronous reset in the middle of RUN
        applyStimulus(OP_DIV, 32'd77777, 32'hFFFF_FFFD, 5'd11, 1'b0, waited);
        repeat (20) tick();
        reset = 1'b0;
        #1;
        checkVal("mid_rst_busy", 64'(busy), 64'd0);
        checkVal("mid_rst_out_valid", 64'(out_valid), 64'd0);
        checkVal("mid_rst_result", 64'(result), 64'd0);
        checkVal("mid_rst_out_tag", 64'(out_tag), 64'd0);
        checkVal("mid_rst_exception", 64'(exception), 64'd0);
        checkVal("mid_rst_in_ready", 64'(in_ready), 64'd1);
        tick();
        reset = 1'b1;
        tick();
        applyStimulus(OP_DIV, 32'd77777, 32'hFFFF_FFFD, 5'd11, 1'b1, waited);
        checkOutput(RUN_LAT);
        consume();

        // A few random ops, one forced divide by zero
        for (int i = 0; i < 6; i++) begin
            rOp = (i % 2 == 1) ? OP_DIV : OP_MUL;
            rA = $urandom;
            rB = $urandom >> $urandom_range(0, 28);
            if ($urandom_range(0, 1) == 1) rB = -rB;
            if (i == 3) rB = 32'd0;
            applyStimulus(rOp, rA, rB, TAG_W'(12 + i), 1'b1, waited);
            checkOutput(latencyOf(rOp, rB));
            consume();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
